// File: rtl/core_launch_ctrl.sv
// core_launch_ctrl
//   Run controller that sits in front of a processor core and its data memory.
//   A run goes through these steps:
//     1. Stream LOAD_N input bytes into dat_mem starting at address 0.
//     2. Release the core from reset.
//     3. Wait for core_done, or abort after TIMEOUT cycles.
//     4. Stream UNLOAD_N result bytes out, starting at UNLOAD_BASE.
//     5. Hold done until req drops.
//   Outside RUN this block owns the dat_mem port and keeps the core in reset.
// Ports
//   clk, reset_n              clock / async active-low reset
//   req                       level start request, held until done is seen
//   in_valid/in_ready/in_data input byte stream (LOAD)
//   out_valid/out_ready/out_data  result byte stream (UNLOAD)
//   mem_own, mem_wr_en, mem_addr, mem_dat_in, mem_dat_out  dat_mem port
//   core_reset, core_done     core control / status
//   busy, done, timeout, cycle_count  run status
module core_launch_ctrl #(
  parameter int AW          = 8,
  parameter int LOAD_N      = 64,
  parameter int UNLOAD_BASE = 64,
  parameter int UNLOAD_N    = 32,
  parameter int TIMEOUT     = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat_in,
  input  logic [7:0]    mem_dat_out,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   cycle_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  // Zero-length phases are skipped at elaboration time.
  localparam logic [2:0] S_AFTER_IDLE = (LOAD_N   == 0) ? S_RUN    : S_LOAD;
  localparam logic [2:0] S_AFTER_RUN  = (UNLOAD_N == 0) ? S_FINISH : S_UNLOAD;

  // Beat index counts 0..N-1 separately from addr, because addr wraps.
  localparam int NMAX = (LOAD_N > UNLOAD_N) ? LOAD_N : UNLOAD_N;
  localparam int BW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BW-1:0] LAST_LOAD   = BW'((LOAD_N   > 0) ? LOAD_N - 1   : 0);
  localparam logic [BW-1:0] LAST_UNLOAD = BW'((UNLOAD_N > 0) ? UNLOAD_N - 1 : 0);
  localparam logic [TW-1:0] LAST_RUN    = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] UNLOAD_A0   = AW'(UNLOAD_BASE);

  logic [2:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [BW-1:0] r_beat;
  logic [TW-1:0] r_run_cnt;   // RUN cycles elapsed, independent of the saturating report
  logic [15:0]   r_cyc;
  logic          r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_beat    <= '0;
      r_run_cnt <= '0;
      r_cyc     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req) begin
          r_addr    <= '0;
          r_beat    <= '0;
          r_run_cnt <= '0;
          r_cyc     <= '0;
          r_timeout <= 1'b0;
          r_state   <= S_AFTER_IDLE;
        end
        S_LOAD: if (in_valid) begin
          r_addr <= r_addr + AW'(1);
          r_beat <= r_beat + BW'(1);
          if (r_beat == LAST_LOAD) r_state <= S_RUN;
        end
        S_RUN: begin
          r_cyc     <= (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;
          r_run_cnt <= r_run_cnt + TW'(1);
          // core_done has priority over the timeout in the same cycle.
          if (core_done) begin
            r_addr  <= UNLOAD_A0;
            r_beat  <= '0;
            r_state <= S_AFTER_RUN;
          end else if (r_run_cnt == LAST_RUN) begin
            r_timeout <= 1'b1;
            r_state   <= S_FINISH;
          end
        end
        S_UNLOAD: if (out_ready) begin
          r_addr <= r_addr + AW'(1);
          r_beat <= r_beat + BW'(1);
          if (r_beat == LAST_UNLOAD) r_state <= S_FINISH;
        end
        S_FINISH: if (!req) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_LOAD);
  assign mem_wr_en   = (r_state == S_LOAD) & in_valid;
  assign mem_addr    = r_addr;
  assign mem_dat_in  = in_data;
  assign out_valid   = (r_state == S_UNLOAD);
  assign out_data    = mem_dat_out;
  assign mem_own     = (r_state != S_RUN);
  assign core_reset  = (r_state != S_RUN);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign timeout     = r_timeout;
  assign cycle_count = r_cyc;

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Bench for core_launch_ctrl.
//   u0 uses the default geometry.
//   u1 skips LOAD, unloads across the address wrap and has a short TIMEOUT.
// Each instance is backed by a small dat_mem model. The bench keeps its own
// reference image of the memory contents; expected unload data is read from
// that image.
module tb_core_launch_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // ---------------- instance 0 : default parameters ----------------
  logic       s0_req = 0, s0_in_valid = 0, s0_out_ready = 0, s0_core_done = 0;
  logic [7:0] s0_in_data = 0;
  logic       s0_in_ready, s0_out_valid, s0_mem_own, s0_mem_wr_en, s0_core_reset;
  logic       s0_busy, s0_done, s0_timeout;
  logic [7:0] s0_out_data, s0_mem_addr, s0_mem_dat_in, s0_mem_dat_out;
  logic [15:0] s0_cycle_count;

  core_launch_ctrl u0 (
    .clk(clk), .reset_n(reset_n), .req(s0_req),
    .in_valid(s0_in_valid), .in_data(s0_in_data), .in_ready(s0_in_ready),
    .out_valid(s0_out_valid), .out_data(s0_out_data), .out_ready(s0_out_ready),
    .mem_own(s0_mem_own), .mem_wr_en(s0_mem_wr_en), .mem_addr(s0_mem_addr),
    .mem_dat_in(s0_mem_dat_in), .mem_dat_out(s0_mem_dat_out),
    .core_reset(s0_core_reset), .core_done(s0_core_done),
    .busy(s0_busy), .done(s0_done), .timeout(s0_timeout),
    .cycle_count(s0_cycle_count)
  );

  // ---------------- instance 1 : wrap / skip-load ----------------
  logic       s1_req = 0, s1_in_valid = 0, s1_out_ready = 0, s1_core_done = 0;
  logic [7:0] s1_in_data = 0;
  logic       s1_in_ready, s1_out_valid, s1_mem_own, s1_mem_wr_en, s1_core_reset;
  logic       s1_busy, s1_done, s1_timeout;
  logic [7:0] s1_out_data, s1_mem_addr, s1_mem_dat_in, s1_mem_dat_out;
  logic [15:0] s1_cycle_count;

  core_launch_ctrl #(.AW(8), .LOAD_N(0), .UNLOAD_BASE(250), .UNLOAD_N(10), .TIMEOUT(50)) u1 (
    .clk(clk), .reset_n(reset_n), .req(s1_req),
    .in_valid(s1_in_valid), .in_data(s1_in_data), .in_ready(s1_in_ready),
    .out_valid(s1_out_valid), .out_data(s1_out_data), .out_ready(s1_out_ready),
    .mem_own(s1_mem_own), .mem_wr_en(s1_mem_wr_en), .mem_addr(s1_mem_addr),
    .mem_dat_in(s1_mem_dat_in), .mem_dat_out(s1_mem_dat_out),
    .core_reset(s1_core_reset), .core_done(s1_core_done),
    .busy(s1_busy), .done(s1_done), .timeout(s1_timeout),
    .cycle_count(s1_cycle_count)
  );

  // ---------------- dat_mem models ----------------
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  logic [7:0] img0 [0:255];
  logic [7:0] img1 [0:255];
  logic [7:0] ref0 [0:255];
  logic [7:0] ref1 [0:255];
  logic       mem_init = 1'b0;

  assign s0_mem_dat_out = mem0[s0_mem_addr];
  assign s1_mem_dat_out = mem1[s1_mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) begin
        mem0[a] <= img0[a];
        mem1[a] <= img1[a];
      end
    end else begin
      if (s0_mem_own && s0_mem_wr_en) mem0[s0_mem_addr] <= s0_mem_dat_in;
      if (s1_mem_own && s1_mem_wr_en) mem1[s1_mem_addr] <= s1_mem_dat_in;
    end
  end

  // ---------------- stimulus helpers (observe only, no checks) ----------------
  int         rdy_bad;
  int         run_cycles;
  bit         saw_ov;
  int         rst_bad;
  int         stall_bad;
  logic [7:0] q_data[$];
  logic [7:0] q_addr[$];

  // Entered at a negedge with u0 in LOAD. Returns at the negedge after the last beat.
  task automatic load0(input int n, input bit gaps, input bit seq);
    int i = 0;
    int guard = 0;
    rdy_bad = 0;
    while (i < n && guard < 2000) begin
      guard++;
      if (gaps && ($urandom % 3 == 0)) begin
        s0_in_valid = 1'b0;
      end else begin
        s0_in_valid = 1'b1;
        s0_in_data  = seq ? 8'(i) : 8'($urandom);
        if (s0_in_ready !== 1'b1) rdy_bad++;
        ref0[i] = s0_in_data;
        i++;
      end
      @(negedge clk);
    end
    s0_in_valid = 1'b0;
  endtask

  // Counts RUN cycles, pulsing core_done in RUN cycle done_at (0 = never).
  task automatic run0(input int done_at);
    int c = 1;
    saw_ov  = 0;
    rst_bad = 0;
    while (s0_mem_own === 1'b0 && c <= 6000) begin
      if (s0_core_reset !== 1'b0) rst_bad++;
      if (s0_out_valid === 1'b1) saw_ov = 1;
      s0_core_done = (c == done_at);
      @(negedge clk);
      s0_core_done = 1'b0;
      c++;
    end
    run_cycles = c - 1;
  endtask

  task automatic unload0(input bit rand_rdy);
    int         guard = 0;
    bit         rdy;
    logic [7:0] pd, pa;
    q_data.delete();
    q_addr.delete();
    stall_bad = 0;
    while (s0_out_valid === 1'b1 && guard < 2000) begin
      guard++;
      rdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
      s0_out_ready = rdy;
      pd = s0_out_data;
      pa = s0_mem_addr;
      if (rdy) begin
        q_data.push_back(s0_out_data);
        q_addr.push_back(s0_mem_addr);
      end
      @(negedge clk);
      if (!rdy && s0_out_valid === 1'b1 && (s0_out_data !== pd || s0_mem_addr !== pa))
        stall_bad++;
    end
    s0_out_ready = 1'b0;
  endtask

  task automatic unload1();
    int guard = 0;
    bit rdy;
    q_data.delete();
    q_addr.delete();
    while (s1_out_valid === 1'b1 && guard < 500) begin
      guard++;
      rdy = 1'($urandom % 2);
      s1_out_ready = rdy;
      if (rdy) begin
        q_data.push_back(s1_out_data);
        q_addr.push_back(s1_mem_addr);
      end
      @(negedge clk);
    end
    s1_out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_total++; if (s0_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", s0_busy); else n_pass++;
    n_total++; if (s0_core_reset !== 1'b1) $display("FAIL reset_core_reset got=%b exp=1", s0_core_reset); else n_pass++;
    n_total++; if (s0_mem_own !== 1'b1) $display("FAIL reset_mem_own got=%b exp=1", s0_mem_own); else n_pass++;
    n_total++; if ({s0_in_ready, s0_out_valid, s0_mem_wr_en, s0_done, s0_timeout} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {s0_in_ready, s0_out_valid, s0_mem_wr_en, s0_done, s0_timeout}); else n_pass++;
    n_total++; if (s0_cycle_count !== 16'd0) $display("FAIL reset_cycle_count got=%0d exp=0", s0_cycle_count); else n_pass++;
    n_total++; if (s1_core_reset !== 1'b1 || s1_busy !== 1'b0)
      $display("FAIL reset_u1 got core_reset=%b busy=%b exp 1/0", s1_core_reset, s1_busy); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int bad = 0;
    s0_req = 1'b1;
    @(negedge clk);
    load0(10, 1'b0, 1'b0);
    s0_req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_total++; if (s0_core_reset !== 1'b1) $display("FAIL midload_core_reset got=%b exp=1", s0_core_reset); else n_pass++;
    n_total++; if (s0_in_ready !== 1'b0) $display("FAIL midload_in_ready got=%b exp=0", s0_in_ready); else n_pass++;
    n_total++; if (s0_busy !== 1'b0) $display("FAIL midload_busy got=%b exp=0", s0_busy); else n_pass++;
    for (int i = 0; i < 10; i++) if (mem0[i] !== ref0[i]) bad++;
    n_total++; if (bad != 0) $display("FAIL midload_mem_kept got=%0d bad bytes exp=0", bad); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (s0_busy !== 1'b0 || s0_mem_addr !== 8'd0)
      $display("FAIL midload_idle got busy=%b addr=%0d exp 0/0", s0_busy, s0_mem_addr); else n_pass++;
  endtask

  task automatic test_full_run();
    int bad = 0;
    s0_req = 1'b1;
    @(negedge clk);
    load0(64, 1'b0, 1'b1);
    n_total++; if (rdy_bad != 0) $display("FAIL full_in_ready got=%0d drops exp=0", rdy_bad); else n_pass++;
    for (int i = 0; i < 64; i++) if (mem0[i] !== 8'(i)) bad++;
    n_total++; if (bad != 0) $display("FAIL full_mem_image got=%0d bad bytes exp=0", bad); else n_pass++;
    run0(100);
    n_total++; if (run_cycles != 100 || rst_bad != 0)
      $display("FAIL full_run_len got=%0d rst_bad=%0d exp=100/0", run_cycles, rst_bad); else n_pass++;
    unload0(1'b0);
    bad = 0;
    for (int j = 0; j < q_data.size(); j++)
      if (q_data[j] !== ref0[64 + j] || q_addr[j] !== 8'(64 + j)) bad++;
    n_total++; if (q_data.size() != 32 || bad != 0)
      $display("FAIL full_unload got=%0d beats %0d bad exp=32/0", q_data.size(), bad); else n_pass++;
    n_total++; if (s0_done !== 1'b1 || s0_timeout !== 1'b0 || s0_core_reset !== 1'b1)
      $display("FAIL full_finish got done=%b to=%b cr=%b exp 1/0/1", s0_done, s0_timeout, s0_core_reset); else n_pass++;
    n_total++; if (s0_cycle_count !== 16'd100) $display("FAIL full_cycle_count got=%0d exp=100", s0_cycle_count); else n_pass++;
    s0_req = 1'b0;
    @(negedge clk);
    n_total++; if (s0_done !== 1'b0 || s0_busy !== 1'b0)
      $display("FAIL full_idle got done=%b busy=%b exp 0/0", s0_done, s0_busy); else n_pass++;
  endtask

  task automatic test_stall_unload();
    int bad = 0;
    int dat = $urandom_range(300, 1);
    s0_req = 1'b1;
    @(negedge clk);
    load0(64, 1'b1, 1'b0);
    run0(dat);
    unload0(1'b1);
    for (int j = 0; j < q_data.size(); j++)
      if (q_data[j] !== ref0[64 + j] || q_addr[j] !== 8'(64 + j)) bad++;
    n_total++; if (q_data.size() != 32 || bad != 0)
      $display("FAIL stall_unload got=%0d beats %0d bad exp=32/0", q_data.size(), bad); else n_pass++;
    n_total++; if (stall_bad != 0) $display("FAIL stall_stable got=%0d changes exp=0", stall_bad); else n_pass++;
    n_total++; if (s0_cycle_count !== 16'(dat)) $display("FAIL stall_cycle_count got=%0d exp=%0d", s0_cycle_count, dat); else n_pass++;
    s0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    s0_req = 1'b1;
    @(negedge clk);
    load0(64, 1'b0, 1'b0);
    run0(0);
    n_total++; if (run_cycles != 4096) $display("FAIL timeout_len got=%0d exp=4096", run_cycles); else n_pass++;
    n_total++; if (saw_ov || s0_out_valid !== 1'b0)
      $display("FAIL timeout_out_valid got=%b exp=0", saw_ov | s0_out_valid); else n_pass++;
    n_total++; if (s0_done !== 1'b1 || s0_timeout !== 1'b1)
      $display("FAIL timeout_flags got done=%b to=%b exp 1/1", s0_done, s0_timeout); else n_pass++;
    n_total++; if (s0_cycle_count !== 16'd4096) $display("FAIL timeout_cycle_count got=%0d exp=4096", s0_cycle_count); else n_pass++;
    s0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_finish_hold();
    int bad = 0;
    int dat = $urandom_range(20, 1);
    s0_req = 1'b1;
    @(negedge clk);
    load0(64, 1'b0, 1'b0);
    run0(37);
    unload0(1'b0);
    for (int k = 0; k < 20; k++) begin
      s0_core_done = 1'($urandom % 2);   // must be ignored outside RUN
      @(negedge clk);
      if (s0_done !== 1'b1 || s0_busy !== 1'b1 || s0_out_valid !== 1'b0 || s0_cycle_count !== 16'd37) bad++;
    end
    s0_core_done = 1'b0;
    n_total++; if (bad != 0) $display("FAIL hold_finish got=%0d bad cycles exp=0", bad); else n_pass++;
    s0_req = 1'b0;
    @(negedge clk);
    n_total++; if (s0_done !== 1'b0 || s0_busy !== 1'b0)
      $display("FAIL hold_release got done=%b busy=%b exp 0/0", s0_done, s0_busy); else n_pass++;
    s0_req = 1'b1;
    @(negedge clk);
    load0(64, 1'b0, 1'b0);
    run0(dat);
    unload0(1'b0);
    n_total++; if (s0_cycle_count !== 16'(dat) || s0_timeout !== 1'b0)
      $display("FAIL hold_rerun got=%0d to=%b exp=%0d/0", s0_cycle_count, s0_timeout, dat); else n_pass++;
    s0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int c = 1;
    int bad = 0;
    s1_req = 1'b1;
    @(negedge clk);
    // LOAD_N=0: straight into RUN
    n_total++; if (s1_mem_own !== 1'b0 || s1_in_ready !== 1'b0)
      $display("FAIL wrap_skip_load got own=%b rdy=%b exp 0/0", s1_mem_own, s1_in_ready); else n_pass++;
    // core_done in the same cycle the timeout fires: done wins
    while (s1_mem_own === 1'b0 && c <= 200) begin
      s1_core_done = (c == 50);
      @(negedge clk);
      s1_core_done = 1'b0;
      c++;
    end
    unload1();
    for (int j = 0; j < q_data.size(); j++)
      if (q_data[j] !== ref1[(250 + j) % 256] || q_addr[j] !== 8'((250 + j) % 256)) bad++;
    n_total++; if (q_data.size() != 10 || bad != 0)
      $display("FAIL wrap_unload got=%0d beats %0d bad exp=10/0", q_data.size(), bad); else n_pass++;
    n_total++; if (s1_done !== 1'b1 || s1_timeout !== 1'b0 || s1_cycle_count !== 16'd50)
      $display("FAIL wrap_done_wins got done=%b to=%b cc=%0d exp 1/0/50", s1_done, s1_timeout, s1_cycle_count); else n_pass++;
    s1_req = 1'b0;
    @(negedge clk);
    s1_req = 1'b1;
    @(negedge clk);
    c = 1;
    while (s1_mem_own === 1'b0 && c <= 200) begin
      @(negedge clk);
      c++;
    end
    n_total++; if (c - 1 != 50 || s1_timeout !== 1'b1 || s1_out_valid !== 1'b0 || s1_cycle_count !== 16'd50)
      $display("FAIL wrap_timeout got len=%0d to=%b ov=%b cc=%0d exp 50/1/0/50", c - 1, s1_timeout, s1_out_valid, s1_cycle_count); else n_pass++;
    s1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      img0[a] = 8'($urandom);
      img1[a] = 8'($urandom);
      ref0[a] = img0[a];
      ref1[a] = img1[a];
    end
    mem_init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset_mid_load();
    test_full_run();
    test_stall_unload();
    test_timeout();
    test_finish_hold();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
